// File: rtl/escaner_teclado.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time, samples the
// synchronized rows at the end of each column period and debounces whole-frame results.
module escaner_teclado #(
  parameter int DIV_ESCANEO = 50000,
  parameter int REBOTE      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  output logic [3:0] tecla,
  output logic       tecla_valida,
  output logic       tecla_presionada
);

  localparam int DW = $clog2(DIV_ESCANEO);
  localparam int CW = $clog2(REBOTE + 1);

  localparam logic [1:0] INACTIVO   = 2'd0;
  localparam logic [1:0] VERIFICAR  = 2'd1;
  localparam logic [1:0] PRESIONADA = 2'd2;
  localparam logic [1:0] LIBERAR    = 2'd3;

  logic [3:0]    sync1_q, sync2_q;
  logic [DW-1:0] div_q;
  logic [1:0]    col_q;
  logic [1:0]    acc_n_q, acc_n_d;
  logic [3:0]    acc_code_q, acc_code_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    tecla_q, tecla_d;
  logic          valida_q, valida_d;

  logic       muestra, fin_frame, unica;
  logic [3:0] bajas;
  logic [2:0] n_col, suma;
  logic [1:0] fila_idx, tot;
  logic [3:0] code;

  assign muestra   = (div_q == DW'(DIV_ESCANEO - 1));
  assign fin_frame = muestra && (col_q == 2'd3);
  assign bajas     = ~sync2_q;
  assign columnas  = ~(4'b0001 << col_q);

  // Frame classification: low-row count accumulated across columns, saturated at 2 (MULTIPLE).
  always_comb begin
    fila_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bajas[i]) fila_idx = 2'(i);
    end
    n_col = {2'b00, bajas[0]} + {2'b00, bajas[1]} + {2'b00, bajas[2]} + {2'b00, bajas[3]};
    suma  = {1'b0, acc_n_q} + n_col;
    tot   = (suma >= 3'd2) ? 2'd2 : suma[1:0];
    code  = (acc_n_q == 2'd1) ? acc_code_q : {fila_idx, col_q};
    unica = (tot == 2'd1);
    acc_n_d    = acc_n_q;
    acc_code_d = acc_code_q;
    if (muestra) begin
      if (col_q == 2'd3) begin
        acc_n_d    = 2'd0;
        acc_code_d = 4'h0;
      end else begin
        acc_n_d = tot;
        if (unica) acc_code_d = code;
      end
    end
  end

  assign cnt_inc = (cnt_q == CW'(REBOTE)) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    tecla_d  = tecla_q;
    valida_d = 1'b0;
    if (fin_frame) begin
      case (state_q)
        INACTIVO: begin
          if (unica) begin
            cand_d = code;
            if (REBOTE == 1) begin
              state_d  = PRESIONADA;
              tecla_d  = code;
              valida_d = 1'b1;
              cnt_d    = CW'(REBOTE);
            end else begin
              state_d = VERIFICAR;
              cnt_d   = CW'(1);
            end
          end
        end
        VERIFICAR: begin
          if (unica && code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(REBOTE)) begin
              state_d  = PRESIONADA;
              tecla_d  = cand_q;
              valida_d = 1'b1;
            end
          end else begin
            state_d = INACTIVO;
            cnt_d   = '0;
          end
        end
        PRESIONADA: begin
          if (!unica) begin
            if (REBOTE == 1) begin
              state_d = INACTIVO;
              cnt_d   = '0;
            end else begin
              state_d = LIBERAR;
              cnt_d   = CW'(1);
            end
          end
        end
        default: begin
          // A key seen again during release debounce returns silently to the held state.
          if (unica) begin
            state_d = PRESIONADA;
            cnt_d   = CW'(REBOTE);
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(REBOTE)) begin
              state_d = INACTIVO;
              cnt_d   = '0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 4'b1111;
      sync2_q    <= 4'b1111;
      div_q      <= '0;
      col_q      <= 2'd0;
      acc_n_q    <= 2'd0;
      acc_code_q <= 4'h0;
      state_q    <= INACTIVO;
      cnt_q      <= '0;
      cand_q     <= 4'h0;
      tecla_q    <= 4'h0;
      valida_q   <= 1'b0;
    end else begin
      sync1_q    <= filas;
      sync2_q    <= sync1_q;
      div_q      <= muestra ? '0 : div_q + DW'(1);
      col_q      <= muestra ? col_q + 2'd1 : col_q;
      acc_n_q    <= acc_n_d;
      acc_code_q <= acc_code_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      tecla_q    <= tecla_d;
      valida_q   <= valida_d;
    end
  end

  assign tecla            = tecla_q;
  assign tecla_valida     = valida_q;
  assign tecla_presionada = (state_q == PRESIONADA) || (state_q == LIBERAR);

endmodule
